mem_arb: RTL and testbench

- Shares one unified single-port memory between the instruction-fetch path and the load/store path of the CPU.
- Arbitrates requests and issues one memory transaction at a time.
- Routes each response back to the requester that issued it.
- Data accesses win by default; a starvation counter guarantees fetch progress.

---
 rtl/mem_arb_if.sv | 52 +++++
 rtl/mem_arb.sv | 101 ++++++++++
 tb/tb_mem_arb.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
// slave  : the arbiter's view (takes requests, drives grants/responses and the memory request).
// master : the surrounding system's view (CPU ports plus memory model).
interface mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // instruction-fetch port
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;

    // load/store port
    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    // shared memory port
    logic            m_req;
    logic            m_we;
    logic [DW/8-1:0] m_be;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_gnt;
    logic            m_rvalid;
    logic [DW-1:0]   m_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_be, m_addr, m_wdata,
        input  m_gnt, m_rvalid, m_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_gnt, m_rvalid, m_rdata
    );
endinterface

// File: rtl/mem_arb.sv
// Fetch vs. load/store arbiter in front of one single-port memory.
// One transaction in flight at a time; data wins unless fetch has been
// passed over STARVE_MAX times in a row while waiting.
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   IDLE     | no transaction in flight; pick a winner and issue m_req
//   WAIT_RSP | transaction accepted; wait for m_rvalid, route to owner
module mem_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input logic        clk,
    input logic        rst,
    mem_arb_if.slave   bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic { IDLE = 1'b0, WAIT_RSP = 1'b1 } state_t;
    typedef enum logic { FETCH = 1'b0, DATA = 1'b1 } owner_t;

    state_t        state_q;
    owner_t        owner_q;
    logic [SW-1:0] starve_q;

    logic starve_full;
    logic win_data;
    logic issue;
    logic grant;
    logic rsp;

    // Winner selection and handshake qualifiers; everything is forced idle while rst is low.
    always_comb begin
        starve_full = (starve_q == SW'(STARVE_MAX));
        win_data    = bus.d_req && !(bus.if_req && starve_full);
        issue       = rst && (state_q == IDLE) && (bus.if_req || bus.d_req);
        grant       = issue && bus.m_gnt;
        rsp         = rst && (state_q == WAIT_RSP) && bus.m_rvalid;
    end

    // Memory-side request mux: fetches are full-word reads with zero write data.
    always_comb begin
        bus.m_req   = issue;
        bus.m_we    = 1'b0;
        bus.m_be    = '0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        if (issue) begin
            if (win_data) begin
                bus.m_we    = bus.d_we;
                bus.m_be    = bus.d_be;
                bus.m_addr  = bus.d_addr;
                bus.m_wdata = bus.d_wdata;
            end else begin
                bus.m_be    = '1;
                bus.m_addr  = bus.if_addr;
            end
        end
    end

    // Grant pulses follow m_gnt in the same cycle; responses go only to the latched owner.
    always_comb begin
        bus.d_gnt     = grant && win_data;
        bus.if_gnt    = grant && !win_data;
        bus.d_rvalid  = rsp && (owner_q == DATA);
        bus.if_rvalid = rsp && (owner_q == FETCH);
        bus.d_rdata   = bus.d_rvalid  ? bus.m_rdata : '0;
        bus.if_rdata  = bus.if_rvalid ? bus.m_rdata : '0;
    end

    // Transaction FSM with owner latch and saturating fetch-starvation counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            owner_q  <= FETCH;
            starve_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q <= WAIT_RSP;
                        if (win_data) begin
                            owner_q <= DATA;
                            if (bus.if_req && !starve_full)
                                starve_q <= starve_q + SW'(1);
                        end else begin
                            owner_q  <= FETCH;
                            starve_q <= '0;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (bus.m_rvalid)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: reset gating, single fetch, data priority,
// starvation release, stalled store, reset mid-transaction, stray responses.
module tb_mem_arb;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arb_if #(.AW(AW), .DW(DW)) bus ();

    mem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Requesters must hold req until granted.
    assert property (@(posedge clk) disable iff (!rst) (bus.if_req && !bus.if_gnt) |=> bus.if_req)
        else $error("if_req dropped before if_gnt");
    assert property (@(posedge clk) disable iff (!rst) (bus.d_req && !bus.d_gnt) |=> bus.d_req)
        else $error("d_req dropped before d_gnt");

    logic any_out;
    assign any_out = |{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                       bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_be     = '0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        bus.m_gnt    = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
    endtask

    int exp_data [7] = '{1, 1, 1, 1, 0, 1, 0};
    int exp_cnt  [7] = '{0, 1, 2, 3, 4, 0, 1};

    initial begin
        // ---- reset: outputs gated even with every input active
        clr_inputs();
        bus.if_req = 1'b1; bus.if_addr = 32'h55; bus.d_req = 1'b1; bus.d_addr = 32'h66;
        bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("rst_outputs_zero", any_out, 0);
        check("rst_state", dut.state_q, 0);
        check("rst_owner", dut.owner_q, 0);
        check("rst_starve", dut.starve_q, 0);
        clr_inputs();
        next_cyc();
        rst = 1'b1;
        next_cyc();

        // ---- 1: lone fetch, zero-wait memory
        bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.m_gnt = 1'b1;
        @(negedge clk);
        check("t1_if_gnt", bus.if_gnt, 1);
        check("t1_d_gnt", bus.d_gnt, 0);
        check("t1_mfields", {bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata},
              {1'b1, 1'b0, 4'hF, 32'h100, 32'h0});
        next_cyc();
        bus.if_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h13;
        @(negedge clk);
        check("t1_if_rvalid", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'h13});
        check("t1_d_rvalid", {bus.d_rvalid, bus.d_rdata}, 0);
        check("t1_mreq_wait", bus.m_req, 0);
        next_cyc();
        bus.m_rvalid = 1'b0; bus.m_rdata = '0;
        @(negedge clk);
        check("t1_idle", dut.state_q, 0);
        check("t1_if_rvalid_off", {bus.if_rvalid, bus.if_rdata}, 0);
        next_cyc();

        // ---- 2: simultaneous fetch and load, starve_cnt=0 -> data first
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000; bus.d_be = 4'hF;
        bus.m_gnt = 1'b1;
        @(negedge clk);
        check("t2_d_gnt", bus.d_gnt, 1);
        check("t2_if_gnt_lose", bus.if_gnt, 0);
        check("t2_maddr", bus.m_addr, 32'h2000);
        next_cyc();
        bus.d_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h55AA;
        @(negedge clk);
        check("t2_d_rvalid", {bus.d_rvalid, bus.d_rdata}, {1'b1, 32'h55AA});
        check("t2_if_rvalid_no", {bus.if_rvalid, bus.if_rdata}, 0);
        next_cyc();
        bus.m_rvalid = 1'b0; bus.m_gnt = 1'b1;
        @(negedge clk);
        check("t2_if_gnt", bus.if_gnt, 1);
        check("t2_maddr_fetch", bus.m_addr, 32'h104);
        check("t2_starve1", dut.starve_q, 1);
        next_cyc();
        bus.if_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h1234;
        @(negedge clk);
        check("t2_if_rvalid", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'h1234});
        next_cyc();
        bus.m_rvalid = 1'b0;

        // ---- 3: starvation: D D D D F D, then fetch alone after data drops
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4000; bus.d_be = 4'hF;
        bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = '0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("t3_starve_%0d", i), dut.starve_q, exp_cnt[i]);
            check($sformatf("t3_gnt_%0d", i), {bus.d_gnt, bus.if_gnt},
                  (exp_data[i] != 0) ? 2'b10 : 2'b01);
            check($sformatf("t3_maddr_%0d", i), bus.m_addr,
                  (exp_data[i] != 0) ? 32'h4000 : 32'h300);
            next_cyc();
            if (i == 5) bus.d_req = 1'b0;
            if (i == 6) bus.if_req = 1'b0;
            bus.m_rdata = 32'hA000 + i;
            @(negedge clk);
            if (exp_data[i] != 0)
                check($sformatf("t3_rsp_%0d", i),
                      {bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata},
                      {1'b1, 32'hA000 + 32'(i), 1'b0, 32'h0});
            else
                check($sformatf("t3_rsp_%0d", i),
                      {bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata},
                      {1'b0, 32'h0, 1'b1, 32'hA000 + 32'(i)});
            next_cyc();
        end
        bus.m_gnt = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
        @(negedge clk);
        check("t3_starve_end", dut.starve_q, 0);
        next_cyc();

        // ---- 4: store stalled 3 cycles by m_gnt
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h3000; bus.d_wdata = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("t4_hold_%0d", k), {bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata},
                  {1'b1, 1'b1, 4'b0011, 32'h3000, 32'hDEADBEEF});
            check($sformatf("t4_no_gnt_%0d", k), bus.d_gnt, 0);
            next_cyc();
        end
        bus.m_gnt = 1'b1;
        @(negedge clk);
        check("t4_d_gnt", bus.d_gnt, 1);
        check("t4_fields", {bus.m_req, bus.m_we, bus.m_be, bus.m_addr, bus.m_wdata},
              {1'b1, 1'b1, 4'b0011, 32'h3000, 32'hDEADBEEF});
        next_cyc();
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1;
        @(negedge clk);
        check("t4_d_rvalid", {bus.d_rvalid, bus.if_rvalid}, 2'b10);
        next_cyc();
        bus.m_rvalid = 1'b0;

        // ---- 5: reset during WAIT_RSP, late response dropped
        bus.if_req = 1'b1; bus.if_addr = 32'h200; bus.m_gnt = 1'b1;
        @(negedge clk);
        check("t5_if_gnt", bus.if_gnt, 1);
        next_cyc();
        bus.if_req = 1'b0; bus.m_gnt = 1'b0;
        @(negedge clk);
        check("t5_wait", dut.state_q, 1);
        #1;
        rst = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h77; bus.m_gnt = 1'b1; bus.m_rvalid = 1'b1; bus.m_rdata = 32'hBAD;
        #1;
        check("t5_rst_outputs_zero", any_out, 0);
        check("t5_rst_state", dut.state_q, 0);
        clr_inputs();
        next_cyc();
        rst = 1'b1;
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hBAD;
        @(negedge clk);
        check("t5_late_rsp_dropped", {bus.if_rvalid, bus.d_rvalid, bus.if_rdata}, 0);
        check("t5_idle", dut.state_q, 0);
        next_cyc();
        bus.m_rvalid = 1'b0; bus.m_rdata = '0;
        bus.if_req = 1'b1; bus.if_addr = 32'h204; bus.m_gnt = 1'b1;
        @(negedge clk);
        check("t5_next_gnt", {bus.if_gnt, bus.m_addr}, {1'b1, 32'h204});
        next_cyc();
        bus.if_req = 1'b0; bus.m_gnt = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = 32'h77;
        @(negedge clk);
        check("t5_next_rsp", {bus.if_rvalid, bus.if_rdata}, {1'b1, 32'h77});
        next_cyc();
        bus.m_rvalid = 1'b0; bus.m_rdata = '0;

        // ---- 6: stray m_rvalid and m_gnt with nothing requested
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFE;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("t6_stray_rsp_%0d", k), {bus.if_rvalid, bus.d_rvalid, bus.m_req}, 0);
            check($sformatf("t6_state_%0d", k), dut.state_q, 0);
            next_cyc();
        end
        bus.m_rvalid = 1'b0; bus.m_gnt = 1'b1;
        @(negedge clk);
        check("t6_stray_gnt", {bus.if_gnt, bus.d_gnt, bus.m_req}, 0);
        next_cyc();
        @(negedge clk);
        check("t6_stray_gnt_state", dut.state_q, 0);
        clr_inputs();
        next_cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
